// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: shared state encoding, default duty width and state helper for the motor drive sequencer.
package motor_seq_pkg;
  localparam int DUTY_W_DEF = 8;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_DEAD      = 3'd3,
    ST_SWITCH    = 3'd4
  } state_t;
  function automatic logic is_driving(input state_t s);
    return (s == ST_RUN) || (s == ST_RAMP_DOWN);
  endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: prescaled free-running PWM with period-aligned shadow duty and registered, run-gated output.
module pwm_gen #(
  parameter int DUTY_W       = 8,
  parameter int PWM_PRESCALE = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DUTY_W-1:0] duty,
  output logic              en
);
  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  logic [PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_shadow;
  logic              r_en;
  logic              w_tick;
  assign w_tick = r_pre == PRE_W'(PWM_PRESCALE - 1);
  assign en     = r_en;
  // shadow is cleared whenever drive stops so a restart never replays a stale duty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_en     <= 1'b0;
    end else begin
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      r_cnt    <= w_tick ? r_cnt + 1'b1 : r_cnt;
      r_shadow <= !run ? '0 : (w_tick && &r_cnt) ? duty : r_shadow;
      r_en     <= run && (r_cnt < r_shadow);
    end
  end
endmodule

// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer: H-bridge EN/DIR sequencer with duty ramping, dead-time and estop handling.
// Optional hall stall detection is built when MOTOR_STALL_DET_EN is defined.
module motor_drive_sequencer
  import motor_seq_pkg::*;
#(
  parameter int DUTY_W           = DUTY_W_DEF,
  parameter int PWM_PRESCALE     = 20,
  parameter int RAMP_STEP_CYCLES = 10_000,
  parameter int DEADTIME_CYCLES  = 100_000,
  parameter int STALL_CYCLES     = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              cmd_enable,
  input  logic              estop,
  input  logic              sa,
  output logic              en,
  output logic              dir,
  output logic [DUTY_W-1:0] cur_duty,
  output logic [2:0]        state_o,
  output logic              stall_fault
);
  localparam int RAMP_W = $clog2(RAMP_STEP_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);
  state_t            r_state, w_next;
  logic [DUTY_W-1:0] r_duty, r_tgt_duty, w_duty_nxt;
  logic              r_tgt_dir, r_tgt_en, r_dir;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic [DEAD_W-1:0] r_dead_cnt;
  logic              w_acc, w_take, w_stop, w_ign, w_step, w_dead_done, w_stall_trip;
  logic              w_up, w_dn;
  assign cmd_ready   = (r_state == ST_IDLE || r_state == ST_RUN) && !estop;
  assign w_acc       = cmd_valid && cmd_ready;
  assign w_take      = w_acc && !w_ign;
  assign w_stop      = estop || w_stall_trip;
  assign w_step      = r_ramp_cnt == RAMP_W'(RAMP_STEP_CYCLES - 1);
  assign w_dead_done = r_dead_cnt == DEAD_W'(DEADTIME_CYCLES - 1);
  assign w_up        = r_duty < r_tgt_duty;
  assign w_dn        = (r_state == ST_RAMP_DOWN) ? (r_duty != '0) : (r_duty > r_tgt_duty);
  assign dir         = r_dir;
  assign cur_duty    = r_duty;
  assign state_o     = r_state;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_take && cmd_enable) w_next = (cmd_dir != r_dir) ? ST_DEAD : ST_RUN;
      ST_RUN:       if (w_take && (!cmd_enable || cmd_dir != r_dir)) w_next = ST_RAMP_DOWN;
      ST_RAMP_DOWN: if (r_duty == '0) w_next = ST_DEAD;
      ST_DEAD:      if (w_dead_done) w_next = r_tgt_en ? ST_SWITCH : ST_IDLE;
      ST_SWITCH:    w_next = ST_RUN;
      default:      w_next = ST_IDLE;
    endcase
    if (w_stop) w_next = ST_DEAD;
  end
  always_comb begin
    w_duty_nxt = (w_stop || !is_driving(r_state)) ? '0 :
                 !w_step                            ? r_duty :
                 (r_state == ST_RUN && w_up)        ? r_duty + 1'b1 :
                 w_dn                               ? r_duty - 1'b1 : r_duty;
  end
  // ramp counter restarts on each state entry so the first step lands a full interval later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_duty     <= '0;
      r_tgt_duty <= '0;
      r_tgt_dir  <= 1'b0;
      r_tgt_en   <= 1'b0;
      r_dir      <= 1'b0;
      r_ramp_cnt <= '0;
      r_dead_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_duty     <= w_duty_nxt;
      r_ramp_cnt <= (w_next != r_state || w_step) ? '0 : r_ramp_cnt + 1'b1;
      r_dead_cnt <= (r_state == ST_DEAD && w_next == ST_DEAD && !w_stop) ? r_dead_cnt + 1'b1 : '0;
      if (w_take) begin
        r_tgt_duty <= cmd_duty;
        r_tgt_dir  <= cmd_dir;
        r_tgt_en   <= cmd_enable;
      end
      if (w_stop) r_tgt_en <= 1'b0;
      if (r_state == ST_SWITCH) r_dir <= r_tgt_dir;
    end
  end
`ifdef MOTOR_STALL_DET_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  logic [1:0]         r_sa_sync;
  logic               r_sa_d;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_stall;
  logic               w_sa_rise, w_stall_run;
  assign w_sa_rise    = r_sa_sync[1] && !r_sa_d;
  assign w_stall_run  = (r_state == ST_RUN) && (r_duty != '0);
  assign w_stall_trip = w_stall_run && !w_sa_rise && (r_stall_cnt == STALL_W'(STALL_CYCLES - 1));
  assign w_ign        = r_stall && cmd_enable;
  assign stall_fault  = r_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa_sync   <= '0;
      r_sa_d      <= 1'b0;
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_sa_sync   <= {r_sa_sync[0], sa};
      r_sa_d      <= r_sa_sync[1];
      r_stall_cnt <= (w_sa_rise || !w_stall_run || w_stall_trip) ? '0 : r_stall_cnt + 1'b1;
      r_stall     <= w_stall_trip ? 1'b1 : (w_acc && !cmd_enable) ? 1'b0 : r_stall;
    end
  end
`else
  logic w_unused_sa;
  assign w_unused_sa  = sa;
  assign w_stall_trip = 1'b0;
  assign w_ign        = 1'b0;
  assign stall_fault  = 1'b0;
`endif
  pwm_gen #(
    .DUTY_W      (DUTY_W),
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_pwm (
    .clk  (clk),
    .reset(reset),
    .run  (is_driving(w_next)),
    .duty (r_duty),
    .en   (en)
  );
endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer: directed checks of ramping, reversal, estop, reset and stall handling.
module tb_motor_drive_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_duty = '0;
  logic       cmd_dir = 1'b0;
  logic       cmd_enable = 1'b0;
  logic       estop = 1'b0;
  logic       sa = 1'b0;
  logic       en, dir, stall_fault;
  logic [7:0] cur_duty;
  logic [2:0] state_o;
  int         n_vec = 0;
  int         n_miss = 0;
  int         hi, bad, n;
  motor_drive_sequencer #(
    .DUTY_W(8), .PWM_PRESCALE(1), .RAMP_STEP_CYCLES(2), .DEADTIME_CYCLES(10), .STALL_CYCLES(1000)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duty(cmd_duty),
    .cmd_dir(cmd_dir), .cmd_enable(cmd_enable), .estop(estop), .sa(sa), .en(en), .dir(dir),
    .cur_duty(cur_duty), .state_o(state_o), .stall_fault(stall_fault)
  );
  always #5 clk = ~clk;
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic r, input logic e);
    cmd_duty = d; cmd_dir = r; cmd_enable = e; cmd_valid = 1'b1;
  endtask
  task automatic count_en(output int h);
    h = 0;
    for (int i = 0; i < 256; i++) begin
      h += int'(en);
      step(1);
    end
  endtask
  initial begin
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst_en", en, 0);
    chk("rst_dir", dir, 0);
    chk("rst_duty", cur_duty, 0);
    chk("rst_state", state_o, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_stall", stall_fault, 0);
    // ramp up from IDLE
    send(8'd64, 1'b0, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    chk("t1_run", state_o, 1);
    chk("t1_duty0", cur_duty, 0);
    step(127);
    chk("t1_duty63", cur_duty, 63);
    step(1);
    chk("t1_duty64", cur_duty, 64);
    step(300);
    count_en(hi);
    chk("t1_en_hi64", hi, 64);
    // reversal: ramp down, dead-time, switch, ramp up
    send(8'd64, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    chk("t2_rampdown", state_o, 2);
    chk("t2_ready0", cmd_ready, 0);
    step(127);
    chk("t2_duty1", cur_duty, 1);
    step(1);
    chk("t2_duty0", cur_duty, 0);
    chk("t2_still_rd", state_o, 2);
    step(1);
    hi = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(en);
      bad += int'(state_o == 3'd3);
      step(1);
    end
    chk("t2_dead_en", hi, 0);
    chk("t2_dead_len", bad, 10);
    chk("t2_switch", state_o, 4);
    chk("t2_dir_hold", dir, 0);
    step(1);
    chk("t2_run", state_o, 1);
    chk("t2_dir1", dir, 1);
    chk("t2_duty_restart", cur_duty, 0);
    step(128);
    chk("t2_duty64", cur_duty, 64);
    // estop at duty 100
    send(8'd100, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    step(100);
    chk("t3_duty100", cur_duty, 100);
    estop = 1'b1;
    step(1);
    chk("t3_en", en, 0);
    chk("t3_duty", cur_duty, 0);
    chk("t3_dead", state_o, 3);
    chk("t3_ready0", cmd_ready, 0);
    estop = 1'b0;
    step(9);
    chk("t3_dead9", state_o, 3);
    step(1);
    chk("t3_idle", state_o, 0);
    chk("t3_dir", dir, 1);
    // reset mid-RUN at duty 50
    send(8'd50, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    chk("t5_run", state_o, 1);
    step(110);
    chk("t5_duty50", cur_duty, 50);
    step(300);
    count_en(hi);
    chk("t5_en_hi50", hi, 50);
    reset = 1'b1;
    step(1);
    chk("t5_en", en, 0);
    chk("t5_dir", dir, 0);
    chk("t5_state", state_o, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_duty", cur_duty, 0);
    reset = 1'b0;
    // held command during ramp-down/dead, then duty 0 target
    send(8'd80, 1'b0, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    step(200);
    chk("t4_duty80", cur_duty, 80);
    send(8'd80, 1'b1, 1'b1);
    step(1);
    chk("t4_rampdown", state_o, 2);
    send(8'd0, 1'b1, 1'b1);
    bad = 0; n = 0;
    while (state_o != 3'd1 && n < 400) begin
      bad += int'(cmd_ready);
      step(1);
      n++;
    end
    chk("t4_reach_run", state_o, 1);
    chk("t4_no_accept", bad, 0);
    chk("t4_ready_run", cmd_ready, 1);
    chk("t4_dir1", dir, 1);
    step(1);
    cmd_valid = 1'b0;
    chk("t4_duty0", cur_duty, 0);
    step(300);
    count_en(hi);
    chk("t4_en_never", hi, 0);
    chk("t4_state_run", state_o, 1);
`ifdef MOTOR_STALL_DET_EN
    send(8'd32, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    n = 0;
    while (!stall_fault && n < 1100) begin
      step(1);
      n++;
    end
    chk("t6_trip_time", (n >= 1001 && n <= 1002), 1);
    chk("t6_fault", stall_fault, 1);
    chk("t6_dead", state_o, 3);
    chk("t6_duty", cur_duty, 0);
    step(10);
    chk("t6_idle", state_o, 0);
    send(8'd32, 1'b1, 1'b1);
    step(1);
    chk("t6_ignored", state_o, 0);
    chk("t6_sticky", stall_fault, 1);
    send(8'd0, 1'b1, 1'b0);
    step(1);
    chk("t6_cleared", stall_fault, 0);
    send(8'd32, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    chk("t6_run", state_o, 1);
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) sa = ~sa;
      step(1);
    end
    chk("t6_toggle_nofault", stall_fault, 0);
    chk("t6_toggle_run", state_o, 1);
`else
    send(8'd32, 1'b1, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    step(1200);
    chk("t6_nofault", stall_fault, 0);
    chk("t6_run", state_o, 1);
    chk("t6_duty32", cur_duty, 32);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
